layer_sequencer: RTL and testbench
==================================

Name: layer_sequencer

Overview:
- Sequences one evaluation pass of a stochastic-bitstream neuron layer.
- On a start request it:
  - holds the layer in reset so its LFSR seeds reload;
  - releases it for a warm-up period;
  - counts the ones on each neuron's output bitstream over a fixed stream length.
- It then presents the per-neuron counts (probability estimates) on a valid/ready result handshake.
- It sits between the network top-level controller and a layer instance, and owns that layer's reset.

Parameters:
- NEURON_COUNT, 2, number of neuron output bitstreams observed.
- STREAM_LENGTH, 256, number of cycles accumulated per pass; must be ≥1.
- WARMUP, 4, cycles the layer runs after reset release before counting starts; 0 allowed.
- COUNT_WIDTH, $clog2(STREAM_LENGTH+1), width of each per-neuron count.

Ports:
- clk  input  1  clock, rising edge.
- n_rst  input  1  asynchronous active-low reset.
- start  input  1  request a pass; sampled only in IDLE.
- abort  input  1  cancel the current pass; any state.
- layer_output  input  NEURON_COUNT  bitstreams from the layer.
- layer_n_rst  output  1  active-low reset driven to the layer.
- busy  output  1  high whenever state ≠ IDLE.
- result_valid  output  1  counts are final and stable.
- result_ready  input  1  consumer accepts the result.
- result_count  output  NEURON_COUNT*COUNT_WIDTH  count for neuron i at bits [i*COUNT_WIDTH +: COUNT_WIDTH].

Behaviour:
- Clocking and reset: one clock (clk). Reset is asynchronous and active-low (n_rst).
- Reset values:
  - state = IDLE;
  - layer_n_rst = 0, busy = 0, result_valid = 0;
  - all result_count = 0;
  - internal cycle counter = 0.
- Outputs are Moore-decoded from registered state and must be glitch-free. layer_n_rst comes from a flop.
- States:
  - IDLE: layer_n_rst = 0. If start=1 and abort=0 → CLEAR.
  - CLEAR, exactly 1 cycle: layer_n_rst = 0; all counts and the cycle counter cleared. Next → WARMUP, or → ACCUM if WARMUP=0.
  - WARMUP, WARMUP cycles: layer_n_rst = 1; layer_output ignored. Exits after cycle counter reaches WARMUP-1; counter reset to 0 on exit.
  - ACCUM, STREAM_LENGTH cycles: layer_n_rst = 1; every cycle count[i] += layer_output[i]. Exits → HOLD after cycle counter reaches STREAM_LENGTH-1, that cycle's sample included.
  - HOLD: layer_n_rst = 0; result_valid = 1; counts frozen. If result_ready=1 → IDLE.
- Latency: start sampled at edge k → result_valid rises at edge k+1+WARMUP+STREAM_LENGTH.
- Counts persist through IDLE after handshake until the next CLEAR.
- Widths and overflow: the count width holds STREAM_LENGTH exactly; no saturation logic is needed. Maximum value is all-ones input for every cycle = STREAM_LENGTH.
- start outside IDLE is ignored. A start held high through HOLD→IDLE launches a new pass on the cycle after returning to IDLE.
- result_ready outside HOLD is ignored. In HOLD, result_valid stays high indefinitely until ready.
- abort=1 in any state → IDLE at the next edge.
  - Counts and cycle counter are cleared.
  - result_valid drops at that edge.
  - abort has priority over start and result_ready in the same cycle.
  - abort in IDLE clears counts.
- Asynchronous reset mid-pass immediately forces all reset values, including layer_n_rst = 0. No partial result is ever presented.

Test Plan (NEURON_COUNT=2, STREAM_LENGTH=16, WARMUP=2):
- Reset release, no start → layer_n_rst=0, busy=0, result_valid=0, result_count=0 held for 20 cycles.
- start pulse at edge k, layer_output=2'b01 constant → busy at k; layer_n_rst=0 in CLEAR, then 1 for 18 cycles; result_valid at k+19; count[0]=16, count[1]=0.
- layer_output alternating 2'b10/2'b11 each cycle, result_ready tied high → count[0]=8, count[1]=16; result_valid high exactly 1 cycle; state returns to IDLE.
- result_ready held low 10 cycles after valid, with layer_output toggling and start pulsed during HOLD → counts unchanged, start ignored, valid stays high; raise ready → IDLE next edge.
- abort asserted on the 5th ACCUM cycle, with start also high → IDLE next edge; counts=0; no result_valid; new pass starts only after abort drops with start high.
- n_rst pulsed low mid-ACCUM → all outputs immediately at reset values; a subsequent full pass with constant 2'b11 gives count[0]=count[1]=16.

Source files
------------

// File: rtl/layer_sequencer.sv
// Runs one pass of a stochastic neuron layer: reset pulse, warm-up, then per-neuron ones counting.
// Latency: start at edge k gives result_valid at edge k+1+WARMUP+STREAM_LENGTH.
// Backpressure: result held in HOLD until result_ready; abort returns to IDLE from any state.
module layer_sequencer #(
  parameter int NEURON_COUNT  = 2,
  parameter int STREAM_LENGTH = 256,
  parameter int WARMUP        = 4,
  parameter int COUNT_WIDTH   = $clog2(STREAM_LENGTH + 1)
) (
  input  logic                                clk,
  input  logic                                n_rst,
  input  logic                                start,
  input  logic                                abort,
  input  logic [NEURON_COUNT-1:0]             layer_output,
  output logic                                layer_n_rst,
  output logic                                busy,
  output logic                                result_valid,
  input  logic                                result_ready,
  output logic [NEURON_COUNT*COUNT_WIDTH-1:0] result_count
);

  localparam int CYC_MAX = (STREAM_LENGTH > WARMUP) ? STREAM_LENGTH : WARMUP;
  localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
  localparam logic [CYC_W-1:0] WARM_LAST = CYC_W'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [CYC_W-1:0] ACC_LAST  = CYC_W'(STREAM_LENGTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WARMUP,
    S_ACCUM,
    S_HOLD
  } state_t;

  state_t                 state, state_nxt;
  logic [CYC_W-1:0]       cycle_cnt;
  logic [COUNT_WIDTH-1:0] counts [NEURON_COUNT];

  // Outputs are registered from the next state so they stay aligned with it and glitch-free.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= S_IDLE;
      layer_n_rst  <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      layer_n_rst  <= (state_nxt == S_WARMUP) || (state_nxt == S_ACCUM);
      busy         <= (state_nxt != S_IDLE);
      result_valid <= (state_nxt == S_HOLD);
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (start) state_nxt = S_CLEAR;
        S_CLEAR:  state_nxt = (WARMUP == 0) ? S_ACCUM : S_WARMUP;
        S_WARMUP: if (cycle_cnt == WARM_LAST) state_nxt = S_ACCUM;
        S_ACCUM:  if (cycle_cnt == ACC_LAST) state_nxt = S_HOLD;
        S_HOLD:   if (result_ready) state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cycle_cnt <= '0;
      for (int i = 0; i < NEURON_COUNT; i++) counts[i] <= '0;
    end else if (abort || state == S_CLEAR) begin
      cycle_cnt <= '0;
      for (int i = 0; i < NEURON_COUNT; i++) counts[i] <= '0;
    end else if (state == S_WARMUP) begin
      cycle_cnt <= (cycle_cnt == WARM_LAST) ? '0 : cycle_cnt + 1'b1;
    end else if (state == S_ACCUM) begin
      cycle_cnt <= (cycle_cnt == ACC_LAST) ? '0 : cycle_cnt + 1'b1;
      for (int i = 0; i < NEURON_COUNT; i++)
        counts[i] <= counts[i] + COUNT_WIDTH'(layer_output[i]);
    end
  end

  for (genvar g = 0; g < NEURON_COUNT; g++) begin : g_pack
    assign result_count[g*COUNT_WIDTH +: COUNT_WIDTH] = counts[g];
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer with NEURON_COUNT=2, STREAM_LENGTH=16, WARMUP=2.
module tb_layer_sequencer;
  localparam int NC = 2;
  localparam int SL = 16;
  localparam int WU = 2;
  localparam int CW = 5;

  logic          clk, n_rst, start, abort, result_ready;
  logic [NC-1:0] layer_output;
  logic          layer_n_rst, busy, result_valid;
  logic [NC*CW-1:0] result_count;
  logic [1:0]    pat_a, pat_b;
  logic          tog;
  int            checks, errors;

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    int         exp0;
    int         exp1;
    int         hold;
  } vec_t;
  vec_t vecs [5];

  layer_sequencer #(
    .NEURON_COUNT(NC), .STREAM_LENGTH(SL), .WARMUP(WU), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
    .layer_output(layer_output), .layer_n_rst(layer_n_rst), .busy(busy),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_count(result_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Layer model: alternate between two patterns on every cycle.
  initial begin
    tog = 1'b0;
    pat_a = 2'b00;
    pat_b = 2'b00;
    layer_output = '0;
    forever begin
      @(negedge clk);
      tog = ~tog;
      layer_output = tog ? pat_a : pat_b;
    end
  end

  function automatic int c0();
    return int'(result_count[CW-1:0]);
  endfunction

  function automatic int c1();
    return int'(result_count[2*CW-1:CW]);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic launch();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("clear_busy", int'(busy), 1);
    check("clear_layer_n_rst", int'(layer_n_rst), 0);
    check("clear_valid", int'(result_valid), 0);
  endtask

  task automatic run_to_result(input int e0, input int e1);
    int lat;
    int ones;
    lat = 0;
    ones = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (result_valid) begin
        lat = i;
        break;
      end
      if (layer_n_rst) ones++;
    end
    check("result_latency", lat, SL + WU + 1);
    check("layer_run_cycles", ones, SL + WU);
    check("count0", c0(), e0);
    check("count1", c1(), e1);
    check("hold_layer_n_rst", int'(layer_n_rst), 0);
    check("hold_busy", int'(busy), 1);
  endtask

  initial begin
    int bad;
    checks = 0;
    errors = 0;
    start = 1'b0;
    abort = 1'b0;
    result_ready = 1'b0;
    n_rst = 1'b1;
    #1 n_rst = 1'b0;

    vecs[0] = '{a: 2'b01, b: 2'b01, exp0: 16, exp1: 0,  hold: 0};
    vecs[1] = '{a: 2'b10, b: 2'b11, exp0: 8,  exp1: 16, hold: 0};
    vecs[2] = '{a: 2'b11, b: 2'b00, exp0: 8,  exp1: 8,  hold: 10};
    vecs[3] = '{a: 2'b00, b: 2'b00, exp0: 0,  exp1: 0,  hold: 0};
    vecs[4] = '{a: 2'b11, b: 2'b11, exp0: 16, exp1: 16, hold: 3};

    repeat (3) @(negedge clk);
    n_rst = 1'b1;

    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (layer_n_rst || busy || result_valid || result_count != '0) bad++;
    end
    check("idle_after_reset_bad_cycles", bad, 0);

    for (int v = 0; v < 5; v++) begin
      pat_a = vecs[v].a;
      pat_b = vecs[v].b;
      result_ready = (vecs[v].hold == 0);
      launch();
      run_to_result(vecs[v].exp0, vecs[v].exp1);
      if (vecs[v].hold != 0) begin
        bad = 0;
        for (int h = 0; h < vecs[v].hold; h++) begin
          start = (h == 2);
          @(negedge clk);
          if (!result_valid || !busy || c0() != vecs[v].exp0 || c1() != vecs[v].exp1) bad++;
        end
        check("hold_stable_bad_cycles", bad, 0);
        start = 1'b0;
        result_ready = 1'b1;
      end
      @(negedge clk);
      check("release_valid", int'(result_valid), 0);
      check("release_busy", int'(busy), 0);
      result_ready = 1'b0;
      @(negedge clk);
      check("idle_stays_busy", int'(busy), 0);
      check("idle_count0_kept", c0(), vecs[v].exp0);
      check("idle_count1_kept", c1(), vecs[v].exp1);
    end

    // Abort on the 5th ACCUM cycle with start also high.
    pat_a = 2'b11;
    pat_b = 2'b11;
    launch();
    repeat (7) @(negedge clk);
    check("pre_abort_count0", c0(), 4);
    check("pre_abort_count1", c1(), 4);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_valid", int'(result_valid), 0);
    check("abort_layer_n_rst", int'(layer_n_rst), 0);
    check("abort_counts", int'(result_count), 0);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (busy || result_valid) bad++;
    end
    check("abort_held_bad_cycles", bad, 0);
    abort = 1'b0;
    launch();
    run_to_result(16, 16);
    result_ready = 1'b1;
    @(negedge clk);
    check("post_abort_release_busy", int'(busy), 0);
    result_ready = 1'b0;

    // Asynchronous reset in the middle of ACCUM.
    launch();
    repeat (8) @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    check("async_rst_layer_n_rst", int'(layer_n_rst), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_valid", int'(result_valid), 0);
    check("async_rst_counts", int'(result_count), 0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check("post_rst_busy", int'(busy), 0);
    launch();
    run_to_result(16, 16);
    result_ready = 1'b1;
    @(negedge clk);
    check("post_rst_release_busy", int'(busy), 0);
    result_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
